// File: rtl/stopwatch_display.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// stopwatch_display
// Drives an 8-digit multiplexed, active-low 7-segment display as H.MM.SS.mmm
// from the stopwatch time outputs.
//
// Each frame works in three steps:
//   1. At the frame boundary the time inputs are snapshotted.
//   2. During the frame, one shared sequential double-dabble engine converts
//      the snapshot to BCD.
//   3. At the next frame boundary the result is committed to the display
//      register.
// Because the display only ever changes at a frame boundary, a frame never
// shows a torn time.
//
// Parameters:
//   SCAN_DIV      clk cycles per digit slot (>= 4)
//   BLANK_CYC     cycles at the start of each slot with all anodes off
//                 (< SCAN_DIV)
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-low reset
//   hours         [3:0] shown raw as one hex digit
//   minutes       [5:0] 0..63
//   seconds       [5:0] 0..63
//   milliseconds  [9:0] 0..1023, values above 999 are shown as 999
//   seg           [6:0] {g,f,e,d,c,b,a}, active-low
//   dp            decimal point, active-low (lit on digits 7, 5 and 3)
//   an            [7:0] digit anodes, active-low; an[7] = hour digit
//   frame_pulse   1-cycle high when a new snapshot is committed
// -----------------------------------------------------------------------------
module stopwatch_display #(
  parameter int SCAN_DIV  = 12500,
  parameter int BLANK_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic [9:0] milliseconds,
  output logic [6:0] seg,
  output logic       dp,
  output logic [7:0] an,
  output logic       frame_pulse
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONV_MS = 3'd1,
    CONV_S  = 3'd2,
    CONV_M  = 3'd3,
    DONE    = 3'd4
  } conv_state_t;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    logic [6:0] on;
    case (digit)
      4'h0:    on = 7'h3F;
      4'h1:    on = 7'h06;
      4'h2:    on = 7'h5B;
      4'h3:    on = 7'h4F;
      4'h4:    on = 7'h66;
      4'h5:    on = 7'h6D;
      4'h6:    on = 7'h7D;
      4'h7:    on = 7'h07;
      4'h8:    on = 7'h7F;
      4'h9:    on = 7'h6F;
      4'hA:    on = 7'h77;
      4'hB:    on = 7'h7C;
      4'hC:    on = 7'h39;
      4'hD:    on = 7'h5E;
      4'hE:    on = 7'h79;
      4'hF:    on = 7'h71;
      default: on = 7'h00;
    endcase
    return ~on;
  endfunction

  // One double-dabble iteration.
  // Add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by one bit.
  function automatic logic [21:0] dd_step(input logic [11:0] bcd,
                                          input logic [9:0]  bin);
    logic [11:0] adj;
    adj = bcd;
    for (int i = 0; i < 3; i++) begin
      if (adj[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
      end else begin
        adj[i*4 +: 4] = adj[i*4 +: 4];
      end
    end
    return {adj[10:0], bin, 1'b0};
  endfunction

  logic [PW-1:0] presc_r;
  logic [PW-1:0] presc_nxt_s;
  logic [2:0]    idx_r;
  logic [2:0]    idx_nxt_s;
  logic          wrap_s;
  logic          commit_s;

  conv_state_t   conv_state_r;
  logic [3:0]    cnt_r;
  logic [11:0]   bcd_r;
  logic [9:0]    bin_r;
  logic [21:0]   dd_s;
  logic [11:0]   res_ms_r;
  logic [7:0]    res_s_r;
  logic [7:0]    res_m_r;
  logic [3:0]    snap_h_r;
  logic [5:0]    snap_m_r;
  logic [5:0]    snap_s_r;

  // Digit nibbles, index k at bits [4k+3:4k]: {h, m tens, m units,
  // s tens, s units, ms hundreds, ms tens, ms units}.
  logic [31:0]   disp_r;
  logic [31:0]   disp_nxt_s;

  logic          blank_s;
  logic [7:0]    an_nxt_s;
  logic [6:0]    seg_nxt_s;
  logic          dp_nxt_s;

  // Next prescaler/digit index. The frame wraps when digit 0 ends its slot.
  always_comb begin
    presc_nxt_s = presc_r;
    idx_nxt_s   = idx_r;
    wrap_s      = 1'b0;
    if (presc_r == PW'(SCAN_DIV - 1)) begin
      presc_nxt_s = '0;
      idx_nxt_s   = idx_r - 3'd1;
      wrap_s      = (idx_r == 3'd0);
    end else begin
      presc_nxt_s = presc_r + PW'(1);
      idx_nxt_s   = idx_r;
      wrap_s      = 1'b0;
    end
  end

  // Scan counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_r <= '0;
      idx_r   <= 3'd7;
    end else begin
      presc_r <= presc_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  assign dd_s = dd_step(bcd_r, bin_r);

  // Converter FSM. At the frame boundary it snapshots the inputs and starts
  // the ms conversion. It then converts seconds and minutes in turn and
  // holds the result in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conv_state_r <= IDLE;
      cnt_r        <= 4'd0;
      bcd_r        <= 12'd0;
      bin_r        <= 10'd0;
      res_ms_r     <= 12'd0;
      res_s_r      <= 8'd0;
      res_m_r      <= 8'd0;
      snap_h_r     <= 4'd0;
      snap_m_r     <= 6'd0;
      snap_s_r     <= 6'd0;
    end else if (wrap_s) begin
      snap_h_r     <= hours;
      snap_m_r     <= minutes;
      snap_s_r     <= seconds;
      // ms enters the engine straight from the inputs: it is only needed
      // in this one cycle, so it gets no snapshot register of its own.
      bin_r        <= (milliseconds > 10'd999) ? 10'd999 : milliseconds;
      bcd_r        <= 12'd0;
      cnt_r        <= 4'd0;
      conv_state_r <= CONV_MS;
    end else begin
      case (conv_state_r)
        CONV_MS: begin
          if (cnt_r == 4'd9) begin
            res_ms_r     <= dd_s[21:10];
            bcd_r        <= 12'd0;
            bin_r        <= {snap_s_r, 4'd0};
            cnt_r        <= 4'd0;
            conv_state_r <= CONV_S;
          end else begin
            {bcd_r, bin_r} <= dd_s;
            cnt_r          <= cnt_r + 4'd1;
          end
        end
        CONV_S: begin
          if (cnt_r == 4'd5) begin
            res_s_r      <= dd_s[17:10];
            bcd_r        <= 12'd0;
            bin_r        <= {snap_m_r, 4'd0};
            cnt_r        <= 4'd0;
            conv_state_r <= CONV_M;
          end else begin
            {bcd_r, bin_r} <= dd_s;
            cnt_r          <= cnt_r + 4'd1;
          end
        end
        CONV_M: begin
          if (cnt_r == 4'd5) begin
            res_m_r      <= dd_s[17:10];
            cnt_r        <= 4'd0;
            conv_state_r <= DONE;
          end else begin
            {bcd_r, bin_r} <= dd_s;
            cnt_r          <= cnt_r + 4'd1;
          end
        end
        IDLE:    conv_state_r <= IDLE;
        DONE:    conv_state_r <= DONE;
        default: conv_state_r <= IDLE;
      endcase
    end
  end

  // Commit only a finished conversion. A boundary that finds the engine
  // idle, which is the first boundary after reset, leaves the display
  // unchanged and gives no frame_pulse.
  assign commit_s   = wrap_s && (conv_state_r == DONE);
  assign disp_nxt_s = commit_s ? {snap_h_r, res_m_r, res_s_r, res_ms_r} : disp_r;

  // Display register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_r <= 32'd0;
    end else begin
      disp_r <= disp_nxt_s;
    end
  end

  // The output registers are computed from the next scan state, so the pins
  // line up with the scan counters in the same cycle.
  always_comb begin
    blank_s   = (presc_nxt_s < PW'(BLANK_CYC));
    an_nxt_s  = 8'hFF;
    seg_nxt_s = 7'h7F;
    dp_nxt_s  = 1'b1;
    if (blank_s) begin
      an_nxt_s  = 8'hFF;
      seg_nxt_s = 7'h7F;
      dp_nxt_s  = 1'b1;
    end else begin
      an_nxt_s  = ~(8'd1 << idx_nxt_s);
      seg_nxt_s = seg_pattern(disp_nxt_s[{idx_nxt_s, 2'b00} +: 4]);
      dp_nxt_s  = ~((idx_nxt_s == 3'd7) || (idx_nxt_s == 3'd5) ||
                    (idx_nxt_s == 3'd3));
    end
  end

  // Registered pin outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an          <= 8'hFF;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_pulse <= 1'b0;
    end else begin
      an          <= an_nxt_s;
      seg         <= seg_nxt_s;
      dp          <= dp_nxt_s;
      frame_pulse <= commit_s;
    end
  end

endmodule
